// File: rtl/mult_accum_pkg.sv
// ============================================================================
// Module   : mult_accum_pkg
// Purpose  : Shared types, default widths and the count-width helper for the
//            product accumulator.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mult_accum_pkg;

    localparam int PROD_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Enough bits to hold the value NUM_TERMS itself.
    function automatic int cnt_w(input int num_terms);
        return $clog2(num_terms + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_prod_accum_if.sv
// ============================================================================
// Module   : mult_prod_accum_if
// Purpose  : Product-in / sum-out valid-ready bundle for mult_prod_accum.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mult_prod_accum_if
    import mult_accum_pkg::*;
#(
    parameter int PROD_W    = PROD_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int NUM_TERMS = 4
);
    localparam int CNT_W = cnt_w(NUM_TERMS);

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );

endinterface

`default_nettype wire

// File: rtl/mult_accum_add.sv
// ============================================================================
// Module   : mult_accum_add
// Purpose  : Zero-extending accumulate adder with carry-out. With
//            MULT_PROD_ACCUM_SAT_EN defined the sum clamps to all ones on carry.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mult_accum_add #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16
) (
    input  wire logic [ACC_W-1:0]  acc_in,
    input  wire logic [PROD_W-1:0] prod,
    output logic      [ACC_W-1:0]  sum,
    output logic                   carry
);

    logic [ACC_W:0] sum_full;

    assign sum_full = {1'b0, acc_in} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    assign carry    = sum_full[ACC_W];

`ifdef MULT_PROD_ACCUM_SAT_EN
    // Once clamped, any further non-zero term carries again, so the sum
    // stays pinned at all ones for the rest of the group.
    assign sum = carry ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
    assign sum = sum_full[ACC_W-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/mult_prod_accum.sv
// ============================================================================
// Module   : mult_prod_accum
// Purpose  : Accumulates a stream of products into groups of up to NUM_TERMS
//            beats and presents each group sum on a registered output.
//            Optional saturation: MULT_PROD_ACCUM_SAT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mult_prod_accum
    import mult_accum_pkg::*;
#(
    parameter int PROD_W    = PROD_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int NUM_TERMS = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         clr,
    mult_prod_accum_if.slave  bus
);

    localparam int CNT_W = cnt_w(NUM_TERMS);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_ovf_q, out_ovf_d;

    logic               in_ready;
    logic               beat;
    logic               first;
    logic               close;
    logic [ACC_W-1:0]   acc_operand;
    logic [ACC_W-1:0]   sum_next;
    logic               carry;
    logic [CNT_W-1:0]   cnt_next;
    logic               ovf_next;

    // in_ready depends on state only, never on out_ready.
    assign in_ready    = (state_q != ST_DONE);
    assign beat        = bus.in_valid & in_ready & ~clr;
    assign first       = (cnt_q == '0);
    assign acc_operand = first ? '0 : acc_q;
    assign cnt_next    = cnt_q + 1'b1;
    assign ovf_next    = (first ? 1'b0 : ovf_q) | carry;
    assign close       = beat & ((cnt_next == CNT_W'(NUM_TERMS)) | bus.in_last);

    mult_accum_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc_in (acc_operand),
        .prod   (bus.in_prod),
        .sum    (sum_next),
        .carry  (carry)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (clr) begin
            state_d     = ST_IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACC: begin
                    if (beat) begin
                        acc_d = sum_next;
                        cnt_d = cnt_next;
                        ovf_d = ovf_next;
                        if (close) begin
                            state_d     = ST_DONE;
                            out_valid_d = 1'b1;
                            out_sum_d   = sum_next;
                            out_count_d = cnt_next;
                            out_ovf_d   = ovf_next;
                        end else begin
                            state_d = ST_ACC;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_prod_accum.sv
// ============================================================================
// Module   : tb_mult_prod_accum
// Purpose  : Directed self-checking bench for mult_prod_accum (default and
//            narrow-accumulator instances). Honours MULT_PROD_ACCUM_SAT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mult_prod_accum;

    logic clk;
    logic rst_n;
    logic clr0;
    logic clr1;

    int n_tests;
    int n_fail;

    mult_prod_accum_if #(.PROD_W(8), .ACC_W(16), .NUM_TERMS(4)) bus0 ();
    mult_prod_accum_if #(.PROD_W(8), .ACC_W(10), .NUM_TERMS(8)) bus1 ();

    mult_prod_accum #(.PROD_W(8), .ACC_W(16), .NUM_TERMS(4)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr0),
        .bus   (bus0)
    );

    mult_prod_accum #(.PROD_W(8), .ACC_W(10), .NUM_TERMS(8)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr1),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat0(input logic [7:0] p, input logic last);
        chk("beat0_in_ready", 32'(bus0.in_ready), 32'd1);
        bus0.in_valid = 1'b1;
        bus0.in_prod  = p;
        bus0.in_last  = last;
        tick();
        bus0.in_valid = 1'b0;
        bus0.in_last  = 1'b0;
    endtask

    task automatic beat1(input logic [7:0] p, input logic last);
        bus1.in_valid = 1'b1;
        bus1.in_prod  = p;
        bus1.in_last  = last;
        tick();
        bus1.in_valid = 1'b0;
        bus1.in_last  = 1'b0;
    endtask

    logic [31:0] exp_wrap_sum;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        clr0    = 1'b0;
        clr1    = 1'b0;
        bus0.in_valid = 1'b0; bus0.in_prod = '0; bus0.in_last = 1'b0; bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_prod = '0; bus1.in_last = 1'b0; bus1.out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_out_valid", 32'(bus0.out_valid), 32'd0);
        chk("rst_out_sum",   32'(bus0.out_sum),   32'd0);
        chk("rst_out_count", 32'(bus0.out_count), 32'd0);
        chk("rst_out_ovf",   32'(bus0.out_ovf),   32'd0);
        chk("rst_in_ready",  32'(bus0.in_ready),  32'd1);

        // Four full beats of 225 close on count
        for (int i = 0; i < 3; i++) beat0(8'd225, 1'b0);
        chk("g1_no_early_valid", 32'(bus0.out_valid), 32'd0);
        beat0(8'd225, 1'b0);
        chk("g1_valid",   32'(bus0.out_valid), 32'd1);
        chk("g1_sum",     32'(bus0.out_sum),   32'd900);
        chk("g1_count",   32'(bus0.out_count), 32'd4);
        chk("g1_ovf",     32'(bus0.out_ovf),   32'd0);
        chk("g1_in_ready",32'(bus0.in_ready),  32'd0);
        tick();
        chk("g1_valid_drop", 32'(bus0.out_valid), 32'd0);
        chk("g1_sum_retain", 32'(bus0.out_sum),   32'd900);

        // Early close, then a fresh group must not see stale acc
        beat0(8'd10, 1'b0);
        beat0(8'd20, 1'b1);
        chk("g2_sum",   32'(bus0.out_sum),   32'd30);
        chk("g2_count", 32'(bus0.out_count), 32'd2);
        tick();
        for (int i = 0; i < 3; i++) beat0(8'd1, 1'b0);
        beat0(8'd1, 1'b1);  // last coincides with NUM_TERMS
        chk("g3_sum",   32'(bus0.out_sum),   32'd4);
        chk("g3_count", 32'(bus0.out_count), 32'd4);
        chk("g3_valid", 32'(bus0.out_valid), 32'd1);
        tick();
        chk("g3_single_close", 32'(bus0.out_valid), 32'd0);

        // Backpressure: result held, new beats refused
        bus0.out_ready = 1'b0;
        beat0(8'd5, 1'b0);
        beat0(8'd6, 1'b0);
        beat0(8'd7, 1'b0);
        beat0(8'd8, 1'b0);
        bus0.in_valid = 1'b1;
        bus0.in_prod  = 8'd99;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",    32'(bus0.out_valid), 32'd1);
            chk("bp_in_ready", 32'(bus0.in_ready),  32'd0);
            chk("bp_sum",      32'(bus0.out_sum),   32'd26);
            tick();
        end
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        chk("bp_valid_before_ack", 32'(bus0.out_valid), 32'd1);
        tick();
        chk("bp_valid_drop", 32'(bus0.out_valid), 32'd0);
        beat0(8'd1, 1'b0);
        beat0(8'd2, 1'b1);
        chk("bp_after_sum",   32'(bus0.out_sum),   32'd3);
        chk("bp_after_count", 32'(bus0.out_count), 32'd2);
        tick();

        // clr discards a partial group and the beat presented with it
        beat0(8'd50, 1'b0);
        beat0(8'd50, 1'b0);
        clr0 = 1'b1;
        bus0.in_valid = 1'b1;
        bus0.in_prod  = 8'd7;
        tick();
        clr0 = 1'b0;
        bus0.in_valid = 1'b0;
        chk("clr_valid", 32'(bus0.out_valid), 32'd0);
        beat0(8'd1, 1'b0);
        beat0(8'd2, 1'b0);
        beat0(8'd3, 1'b1);
        chk("clr_sum",   32'(bus0.out_sum),   32'd6);
        chk("clr_count", 32'(bus0.out_count), 32'd3);
        chk("clr_ovf",   32'(bus0.out_ovf),   32'd0);
        tick();

        // Reset while DONE
        bus0.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat0(8'd9, 1'b0);
        chk("rd_valid_pre", 32'(bus0.out_valid), 32'd1);
        chk("rd_sum_pre",   32'(bus0.out_sum),   32'd36);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rd_valid",    32'(bus0.out_valid), 32'd0);
        chk("rd_sum",      32'(bus0.out_sum),   32'd0);
        chk("rd_in_ready", 32'(bus0.in_ready),  32'd1);
        bus0.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) beat0(8'd3, 1'b0);
        chk("rd_after_sum",   32'(bus0.out_sum),   32'd12);
        chk("rd_after_count", 32'(bus0.out_count), 32'd4);
        tick();

        // Narrow accumulator overflow: 5 x 225 = 1125 > 1023
`ifdef MULT_PROD_ACCUM_SAT_EN
        exp_wrap_sum = 32'd1023;
`else
        exp_wrap_sum = 32'd101;
`endif
        for (int i = 0; i < 4; i++) beat1(8'd225, 1'b0);
        chk("ovf_no_early_valid", 32'(bus1.out_valid), 32'd0);
        beat1(8'd225, 1'b1);
        chk("ovf_valid", 32'(bus1.out_valid), 32'd1);
        chk("ovf_sum",   32'(bus1.out_sum),   exp_wrap_sum);
        chk("ovf_flag",  32'(bus1.out_ovf),   32'd1);
        chk("ovf_count", 32'(bus1.out_count), 32'd5);
        tick();
        beat1(8'd4, 1'b1);
        chk("ovf_next_sum",  32'(bus1.out_sum), 32'd4);
        chk("ovf_next_flag", 32'(bus1.out_ovf), 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
